// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one memory-controller port between two masters:
//     m0 - instruction fetch (read-only)
//     m1 - data load/store
//   Masters are arbitrated round-robin. Each granted access is sequenced
//   through IDLE -> ACCESS -> RESP, with a per-region number of extra ACCESS
//   cycles selected from addr[31:28]:
//     0x0 bram (0), 0x1 sram (SRAM_WAIT), 0x2 flash (FLASH_WAIT),
//     0x4 peripheral (0). Any other region is unmapped: no strobe is issued
//     and the access completes in RESP with err=1.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   m0_req/addr               fetch request, held until m0_ack
//   m0_ack/done/rdata/err     accept strobe, completion pulse, response
//   m1_req/we/addr/wdata      data request, held until m1_ack
//   m1_ack/done/rdata/err     accept strobe, completion pulse, response
//   mem_rd/wr/addr/wdata      strobes and request to the memory controller
//   mem_rdata/err             response from the memory controller
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter logic [3:0] SRAM_WAIT  = 4'd1,
   parameter logic [3:0] FLASH_WAIT = 4'd4
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   output logic        m0_ack,
   output logic        m0_done,
   output logic [31:0] m0_rdata,
   output logic        m0_err,

   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_ack,
   output logic        m1_done,
   output logic [31:0] m1_rdata,
   output logic        m1_err,

   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   state_t      state, state_nxt;
   logic        last_grant;   // master that received the most recent ack
   logic        owner;        // master that owns the access in flight
   logic        we_q;         // access in flight is a write
   logic [3:0]  wait_cnt;     // remaining extra ACCESS cycles

   logic        sel_m1;       // arbitration winner (1 = m1)
   logic        grant;        // an ack is issued this cycle
   logic [31:0] sel_addr;
   logic        sel_mapped;
   logic [3:0]  sel_wait;

   logic        cap_en;       // load the owner's response registers
   logic        cap_owner;
   logic [31:0] cap_rdata;
   logic        cap_err;

   // ------------------------------------------------------------------------
   // Arbitration and region decode of the winning request
   // ------------------------------------------------------------------------
   // NOTE: every signal assigned in an always_comb gets a default first so
   // that no path through the block leaves it unassigned (which would infer
   // a latch).
   always_comb begin
      sel_mapped = 1'b1;
      sel_wait   = 4'd0;

      // With both requests pending the master that was not served last wins.
      sel_m1   = m1_req & (~m0_req | (last_grant == M0));
      // Reset is folded in so no ack can escape while reset is held.
      grant    = (state == IDLE) & (m0_req | m1_req) & ~rst;
      sel_addr = sel_m1 ? m1_addr : m0_addr;

      case (sel_addr[31:28])
         4'h0:    sel_wait   = 4'd0;
         4'h1:    sel_wait   = SRAM_WAIT;
         4'h2:    sel_wait   = FLASH_WAIT;
         4'h4:    sel_wait   = 4'd0;
         default: sel_mapped = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // ------------------------------------------------------------------------
   // FSM: next state and outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      m0_ack    = grant & ~sel_m1;
      m1_ack    = grant &  sel_m1;
      m0_done   = 1'b0;
      m1_done   = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      cap_en    = 1'b0;
      cap_owner = owner;
      cap_rdata = 32'd0;
      cap_err   = 1'b0;

      case (state)
         IDLE: begin
            if (grant) begin
               if (sel_mapped) begin
                  state_nxt = ACCESS;
               end else begin
                  // Unmapped: skip the bus entirely and answer with an error.
                  state_nxt = RESP;
                  cap_en    = 1'b1;
                  cap_owner = sel_m1;
                  cap_err   = 1'b1;
               end
            end
         end

         ACCESS: begin
            mem_rd = ~we_q;
            mem_wr =  we_q;
            if (wait_cnt == 4'd0) begin
               // Final ACCESS cycle: the controller's response is taken here.
               state_nxt = RESP;
               cap_en    = 1'b1;
               cap_rdata = we_q ? 32'd0 : mem_rdata;
               cap_err   = mem_err;
            end
         end

         RESP: begin
            m0_done   = (owner == M0);
            m1_done   = (owner == M1);
            state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Request latch, wait counter and per-master response registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= M1;
         owner      <= M0;
         we_q       <= 1'b0;
         wait_cnt   <= 4'd0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
         m0_rdata   <= 32'd0;
         m0_err     <= 1'b0;
         m1_rdata   <= 32'd0;
         m1_err     <= 1'b0;
      end else begin
         if (grant) begin
            last_grant <= sel_m1;
            owner      <= sel_m1;
            we_q       <= sel_m1 & m1_we;
            mem_addr   <= sel_addr;
            if (sel_m1) mem_wdata <= m1_wdata;
            wait_cnt   <= sel_mapped ? sel_wait : 4'd0;
         end else if (state == ACCESS && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end

         // Response registers change only on completion and hold otherwise.
         if (cap_en) begin
            if (cap_owner == M1) begin
               m1_rdata <= cap_rdata;
               m1_err   <= cap_err;
            end else begin
               m0_rdata <= cap_rdata;
               m0_err   <= cap_err;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Directed stimulus for mem_bus_arbiter. A transaction-level model tracks
//   each granted access as (start cycle, owner, region wait, read/write) and
//   derives the expected outputs of every cycle from its offset inside that
//   access; a single compare process checks the DUT against it on every
//   falling edge. The directed tasks add literal expectations for latency,
//   data and grant order.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

   localparam int SRAM_W  = 1;
   localparam int FLASH_W = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_ack, m0_done, m0_err;
   logic [31:0] m0_addr, m0_rdata;
   logic        m1_req, m1_we, m1_ack, m1_done, m1_err;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic        mem_rd, mem_wr, mem_err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .SRAM_WAIT (4'(SRAM_W)),
      .FLASH_WAIT(4'(FLASH_W))
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .m0_req   (m0_req),
      .m0_addr  (m0_addr),
      .m0_ack   (m0_ack),
      .m0_done  (m0_done),
      .m0_rdata (m0_rdata),
      .m0_err   (m0_err),
      .m1_req   (m1_req),
      .m1_we    (m1_we),
      .m1_addr  (m1_addr),
      .m1_wdata (m1_wdata),
      .m1_ack   (m1_ack),
      .m1_done  (m1_done),
      .m1_rdata (m1_rdata),
      .m1_err   (m1_err),
      .mem_rd   (mem_rd),
      .mem_wr   (mem_wr),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_err  (mem_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Extra ACCESS cycles of a region, or -1 when the region is unmapped.
   function automatic int region_wait(input logic [31:0] a);
      case (a[31:28])
         4'h0:    return 0;
         4'h1:    return SRAM_W;
         4'h2:    return FLASH_W;
         4'h4:    return 0;
         default: return -1;
      endcase
   endfunction

   // ------------------------------------------------------------------------
   // Transaction-level model and per-cycle compare
   // ------------------------------------------------------------------------
   int          cyc = 0;
   bit          busy = 1'b0;
   bit          last_g = 1'b1;
   int          t0, txn_w;
   bit          txn_own, txn_wr;
   logic [31:0] txn_addr, txn_wdata;
   logic [31:0] pend_rdata, exp_addr;
   logic        pend_err;
   logic [31:0] exp_rdata [2];
   logic        exp_err   [2];

   always @(negedge clk) begin
      logic e_ack0, e_ack1, e_rd, e_wr, e_dn0, e_dn1, win;
      int   k, end_k;
      cyc   = cyc + 1;
      e_ack0 = 1'b0; e_ack1 = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
      e_dn0  = 1'b0; e_dn1  = 1'b0; win  = 1'b0;
      k = 0; end_k = 0;

      if (rst) begin
         busy = 1'b0;
         last_g = 1'b1;
         exp_rdata[0] = 32'd0; exp_rdata[1] = 32'd0;
         exp_err[0]   = 1'b0;  exp_err[1]   = 1'b0;
         exp_addr     = 32'd0;
      end else if (busy) begin
         k     = cyc - t0;
         end_k = (txn_w < 0) ? 1 : txn_w + 2;
         if (txn_w >= 0 && k >= 1 && k <= txn_w + 1) begin
            e_rd = !txn_wr;
            e_wr = txn_wr;
         end
         if (txn_w >= 0 && k == txn_w + 1) begin
            pend_rdata = txn_wr ? 32'd0 : mem_rdata;
            pend_err   = mem_err;
         end
         if (k == end_k) begin
            exp_rdata[txn_own] = pend_rdata;
            exp_err[txn_own]   = pend_err;
            if (txn_own) e_dn1 = 1'b1; else e_dn0 = 1'b1;
         end
      end else if (m0_req || m1_req) begin
         win = (m0_req && m1_req) ? !last_g : m1_req;
         if (win) e_ack1 = 1'b1; else e_ack0 = 1'b1;
      end

      check("m0_ack",   {31'd0, m0_ack},  {31'd0, e_ack0});
      check("m1_ack",   {31'd0, m1_ack},  {31'd0, e_ack1});
      check("mem_rd",   {31'd0, mem_rd},  {31'd0, e_rd});
      check("mem_wr",   {31'd0, mem_wr},  {31'd0, e_wr});
      check("m0_done",  {31'd0, m0_done}, {31'd0, e_dn0});
      check("m1_done",  {31'd0, m1_done}, {31'd0, e_dn1});
      check("m0_rdata", m0_rdata, exp_rdata[0]);
      check("m0_err",   {31'd0, m0_err},  {31'd0, exp_err[0]});
      check("m1_rdata", m1_rdata, exp_rdata[1]);
      check("m1_err",   {31'd0, m1_err},  {31'd0, exp_err[1]});
      check("mem_addr", mem_addr, exp_addr);
      if (e_wr) check("mem_wdata", mem_wdata, txn_wdata);

      if (!rst) begin
         if (busy && k == end_k) begin
            busy = 1'b0;
         end else if (!busy && (e_ack0 || e_ack1)) begin
            busy      = 1'b1;
            t0        = cyc;
            txn_own   = win;
            txn_wr    = win & m1_we;
            txn_addr  = win ? m1_addr : m0_addr;
            txn_wdata = m1_wdata;
            txn_w     = region_wait(txn_addr);
            last_g    = win;
            exp_addr  = txn_addr;
            if (txn_w < 0) begin
               pend_rdata = 32'd0;
               pend_err   = 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Directed transaction: request, wait for ack, wait for done, check.
   // rd is the controller read data; with vary set it becomes rd+n in the
   // n-th cycle after the ack. mem_err is high only in cycle err_at.
   // ------------------------------------------------------------------------
   task automatic run_txn(input string name, input logic m, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd, input bit vary, input int err_at,
                          input int exp_lat, input logic [31:0] exp_rd, input logic exp_e);
      int lat;
      bit got;
      @(posedge clk); #1;
      mem_rdata = rd;
      mem_err   = (err_at == 0);
      if (m) begin
         m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
      end else begin
         m0_req = 1'b1; m0_addr = addr;
      end
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((m && m1_ack) || (!m && m0_ack)) begin
            got = 1'b1;
            break;
         end
      end
      check({name, "_ack_seen"}, {31'd0, got}, 32'd1);
      if (!got) begin
         m0_req = 1'b0; m1_req = 1'b0;
         return;
      end
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) begin m0_req = 1'b0; m1_req = 1'b0; end
         if (vary) mem_rdata = rd + 32'(lat);
         mem_err = (lat == err_at);
         @(negedge clk);
         if ((m && m1_done) || (!m && m0_done)) begin
            got = 1'b1;
            break;
         end
      end
      check({name, "_done_seen"}, {31'd0, got}, 32'd1);
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({name, "_rdata"}, m ? m1_rdata : m0_rdata, exp_rd);
      check({name, "_err"}, {31'd0, m ? m1_err : m0_err}, {31'd0, exp_e});
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int seq [4];
      int n, dn, first;
      bit got;
      rst = 1'b1;
      m0_req = 1'b0; m0_addr = 32'd0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
      mem_rdata = 32'd0; mem_err = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Both masters request continuously from reset: m0, m1, m0, m1.
      @(posedge clk); #1;
      mem_rdata = 32'h0BAD_F00D;
      m0_req = 1'b1; m0_addr = 32'h0000_0100;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4000_0020;
      n = 0;
      for (int i = 0; i < 60 && n < 4; i++) begin
         @(negedge clk);
         if (m0_ack) begin seq[n] = 0; n++; end
         else if (m1_ack) begin seq[n] = 1; n++; end
      end
      @(posedge clk); #1;
      m0_req = 1'b0; m1_req = 1'b0;
      check("rr_count", 32'(n), 32'd4);
      check("rr_grant0", 32'(seq[0]), 32'd0);
      check("rr_grant1", 32'(seq[1]), 32'd1);
      check("rr_grant2", 32'(seq[2]), 32'd0);
      check("rr_grant3", 32'(seq[3]), 32'd1);
      repeat (6) @(posedge clk);

      run_txn("bram_rd",   1'b0, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, -1, 2, 32'hDEAD_BEEF, 1'b0);
      run_txn("flash_wr",  1'b1, 1'b1, 32'h2000_0004, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, -1, 6, 32'd0, 1'b0);
      run_txn("unmapped",  1'b1, 1'b0, 32'h3000_0000, 32'd0, 32'hFFFF_FFFF, 1'b0, -1, 1, 32'd0, 1'b1);
      run_txn("sram_err",  1'b0, 1'b0, 32'h1000_0008, 32'd0, 32'h1357_9BDF, 1'b0, 2, 3, 32'h1357_9BDF, 1'b1);
      run_txn("flash_rd",  1'b0, 1'b0, 32'h2000_0100, 32'd0, 32'hA000_0000, 1'b1, 3, 6, 32'hA000_0005, 1'b0);
      run_txn("periph_rd", 1'b1, 1'b0, 32'h4000_0010, 32'd0, 32'h5555_AAAA, 1'b0, -1, 2, 32'h5555_AAAA, 1'b0);
      run_txn("sram_wr",   1'b1, 1'b1, 32'h1000_0000, 32'hCAFE_0001, 32'h7777_7777, 1'b0, -1, 3, 32'd0, 1'b0);
      run_txn("sram_rd",   1'b0, 1'b0, 32'h1000_0040, 32'd0, 32'h2468_ACE0, 1'b1, -1, 3, 32'h2468_ACE2, 1'b0);
      // m1's response from the write above must still be held.
      check("m1_hold_rdata", m1_rdata, 32'd0);
      check("m0_hold_rdata", m0_rdata, 32'h2468_ACE2);

      // Reset during a flash write: strobe drops at once, no done follows.
      @(posedge clk); #1;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h2000_0040; m1_wdata = 32'hCAFE_F00D;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m1_ack) begin got = 1'b1; break; end
      end
      check("rst_txn_ack_seen", {31'd0, got}, 32'd1);
      @(posedge clk); #1;
      m1_req = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_mem_wr", {31'd0, mem_wr}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_mem_wr_drop", {31'd0, mem_wr}, 32'd0);
      check("rst_mem_rd_low", {31'd0, mem_rd}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      dn = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (m0_done || m1_done) dn++;
      end
      check("rst_no_done", 32'(dn), 32'd0);

      @(posedge clk); #1;
      m0_req = 1'b1; m0_addr = 32'h0000_0020;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0024;
      first = -1;
      for (int i = 0; i < 20 && first < 0; i++) begin
         @(negedge clk);
         if (m0_ack) first = 0;
         else if (m1_ack) first = 1;
      end
      @(posedge clk); #1;
      m0_req = 1'b0; m1_req = 1'b0;
      check("post_rst_first_grant", 32'(first), 32'd0);
      repeat (6) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
